// File: rtl/mem_lsu_pkg.sv
// rtl/mem_lsu_pkg.sv - shared op codes, bus widths and FSM encodings for the MEM stage
package mem_lsu_pkg;

    localparam int ALU_OP_W   = 8;
    localparam int REG_W      = 32;
    localparam int REG_ADDR_W = 5;

    localparam logic [ALU_OP_W-1:0] EXE_NOP_OP = 8'b0000_0000;
    localparam logic [ALU_OP_W-1:0] EXE_ADD_OP = 8'b0010_0000;
    localparam logic [ALU_OP_W-1:0] EXE_LB_OP  = 8'b1110_0000;
    localparam logic [ALU_OP_W-1:0] EXE_LH_OP  = 8'b1110_0001;
    localparam logic [ALU_OP_W-1:0] EXE_LW_OP  = 8'b1110_0011;
    localparam logic [ALU_OP_W-1:0] EXE_LBU_OP = 8'b1110_0100;
    localparam logic [ALU_OP_W-1:0] EXE_LHU_OP = 8'b1110_0101;
    localparam logic [ALU_OP_W-1:0] EXE_SB_OP  = 8'b1110_1000;
    localparam logic [ALU_OP_W-1:0] EXE_SH_OP  = 8'b1110_1001;
    localparam logic [ALU_OP_W-1:0] EXE_SW_OP  = 8'b1110_1011;

    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_BUS  = 1'b1
    } lsu_state_e;

    function automatic logic is_load_op(input logic [ALU_OP_W-1:0] op);
        return (op == EXE_LB_OP) || (op == EXE_LH_OP) || (op == EXE_LW_OP) ||
               (op == EXE_LBU_OP) || (op == EXE_LHU_OP);
    endfunction

    function automatic logic is_store_op(input logic [ALU_OP_W-1:0] op);
        return (op == EXE_SB_OP) || (op == EXE_SH_OP) || (op == EXE_SW_OP);
    endfunction

    function automatic logic is_mem_op(input logic [ALU_OP_W-1:0] op);
        return is_load_op(op) || is_store_op(op);
    endfunction

    function automatic logic is_half_op(input logic [ALU_OP_W-1:0] op);
        return (op == EXE_LH_OP) || (op == EXE_LHU_OP) || (op == EXE_SH_OP);
    endfunction

    function automatic logic is_word_op(input logic [ALU_OP_W-1:0] op);
        return (op == EXE_LW_OP) || (op == EXE_SW_OP);
    endfunction

endpackage

// File: rtl/mem_lsu_align.sv
// rtl/mem_lsu_align.sv - byte-lane select, store replication and load extraction
module mem_lsu_align
    import mem_lsu_pkg::*;
(
    input  logic [ALU_OP_W-1:0] aluop_i,
    input  logic [1:0]          off_i,
    input  logic [REG_W-1:0]    reg2_i,
    input  logic [REG_W-1:0]    rdata_i,
    output logic [3:0]          sel_o,
    output logic [REG_W-1:0]    wdata_o,
    output logic [REG_W-1:0]    load_data_o
);

    logic [7:0]  byte_v;
    logic [15:0] half_v;

    // Little-endian lane picks; halfwords only look at offset bit 1.
    assign byte_v = rdata_i[{off_i, 3'b000} +: 8];
    assign half_v = off_i[1] ? rdata_i[31:16] : rdata_i[15:0];

    // Lane enables, replicated store data and extended load data per access size.
    always_comb begin
        sel_o       = 4'b0000;
        wdata_o     = reg2_i;
        load_data_o = '0;
        case (aluop_i)
            EXE_LB_OP, EXE_LBU_OP, EXE_SB_OP: begin
                sel_o       = 4'b0001 << off_i;
                wdata_o     = {4{reg2_i[7:0]}};
                load_data_o = (aluop_i == EXE_LB_OP) ? {{24{byte_v[7]}}, byte_v}
                                                     : {24'h0, byte_v};
            end
            EXE_LH_OP, EXE_LHU_OP, EXE_SH_OP: begin
                sel_o       = 4'b0011 << {off_i[1], 1'b0};
                wdata_o     = {2{reg2_i[15:0]}};
                load_data_o = (aluop_i == EXE_LH_OP) ? {{16{half_v[15]}}, half_v}
                                                     : {16'h0, half_v};
            end
            EXE_LW_OP, EXE_SW_OP: begin
                sel_o       = 4'b1111;
                wdata_o     = reg2_i;
                load_data_o = rdata_i;
            end
            default: begin
                sel_o       = 4'b0000;
                wdata_o     = reg2_i;
                load_data_o = '0;
            end
        endcase
    end

endmodule

// File: rtl/mem_lsu.sv
// rtl/mem_lsu.sv - MEM stage load/store unit with req/ack bus (option: MEM_MISALIGN_TRAP_EN)
module mem_lsu
    import mem_lsu_pkg::*;
#(
    parameter int BUS_TIMEOUT = 0
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [ALU_OP_W-1:0]   aluop_i,
    input  logic [REG_W-1:0]      mem_addr_i,
    input  logic [REG_W-1:0]      reg2_i,
    input  logic [REG_ADDR_W-1:0] wd_i,
    input  logic                  wreg_i,
    input  logic [REG_W-1:0]      wdata_i,
    output logic                  stall_req_o,
    output logic                  mem_req_o,
    output logic                  mem_we_o,
    output logic [REG_W-1:0]      mem_addr_o,
    output logic [3:0]            mem_sel_o,
    output logic [REG_W-1:0]      mem_wdata_o,
    input  logic                  mem_ack_i,
    input  logic [REG_W-1:0]      mem_rdata_i,
    output logic [REG_ADDR_W-1:0] wd_o,
    output logic                  wreg_o,
    output logic [REG_W-1:0]      wdata_o,
    output logic                  misalign_o,
    output logic                  timeout_o
);

    localparam int CNT_W = (BUS_TIMEOUT > 1) ? $clog2(BUS_TIMEOUT) : 1;

    lsu_state_e            state_q, state_d;
    logic [CNT_W-1:0]      cnt_q, cnt_d;
    logic [ALU_OP_W-1:0]   op_q, op_d;
    logic [1:0]            off_q, off_d;
    logic                  req_d, we_d;
    logic [REG_W-1:0]      addr_d, bus_wdata_d;
    logic [3:0]            sel_d;
    logic [REG_ADDR_W-1:0] wd_d;
    logic                  wreg_d;
    logic [REG_W-1:0]      wdata_d;
    logic                  misalign_d, timeout_d, stall;
    logic [ALU_OP_W-1:0]   align_op;
    logic [1:0]            align_off;
    logic [3:0]            align_sel;
    logic [REG_W-1:0]      align_wdata, align_load;
    logic                  misaligned, expire;

    // While on the bus, extraction must use the op/offset captured at issue.
    assign align_op  = (state_q == ST_BUS) ? op_q  : aluop_i;
    assign align_off = (state_q == ST_BUS) ? off_q : mem_addr_i[1:0];

    mem_lsu_align u_align (
        .aluop_i     (align_op),
        .off_i       (align_off),
        .reg2_i      (reg2_i),
        .rdata_i     (mem_rdata_i),
        .sel_o       (align_sel),
        .wdata_o     (align_wdata),
        .load_data_o (align_load)
    );

`ifdef MEM_MISALIGN_TRAP_EN
    assign misaligned = is_mem_op(aluop_i) &&
                        ((is_half_op(aluop_i) && mem_addr_i[0]) ||
                         (is_word_op(aluop_i) && (mem_addr_i[1:0] != 2'b00)));
`else
    assign misaligned = 1'b0;
`endif

    // Expiry on the last permitted wait cycle; a zero timeout never expires.
    assign expire = (BUS_TIMEOUT != 0) && (cnt_q == CNT_W'(BUS_TIMEOUT - 1));

    assign stall_req_o = rst & stall;

    // Next-state, bus fields and MEM/WB result selection.
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        op_d        = op_q;
        off_d       = off_q;
        req_d       = mem_req_o;
        we_d        = mem_we_o;
        addr_d      = mem_addr_o;
        sel_d       = mem_sel_o;
        bus_wdata_d = mem_wdata_o;
        wd_d        = '0;
        wreg_d      = 1'b0;
        wdata_d     = '0;
        misalign_d  = 1'b0;
        timeout_d   = 1'b0;
        stall       = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (is_mem_op(aluop_i)) begin
                    if (misaligned) begin
                        misalign_d = 1'b1;
                    end else begin
                        stall       = 1'b1;
                        state_d     = ST_BUS;
                        cnt_d       = '0;
                        op_d        = aluop_i;
                        off_d       = mem_addr_i[1:0];
                        req_d       = 1'b1;
                        we_d        = is_store_op(aluop_i);
                        addr_d      = {mem_addr_i[REG_W-1:2], 2'b00};
                        sel_d       = align_sel;
                        bus_wdata_d = align_wdata;
                    end
                end else begin
                    wd_d    = wd_i;
                    wreg_d  = wreg_i;
                    wdata_d = wdata_i;
                end
            end
            ST_BUS: begin
                if (mem_ack_i) begin
                    state_d = ST_IDLE;
                    req_d   = 1'b0;
                    if (is_load_op(op_q)) begin
                        wd_d    = wd_i;
                        wreg_d  = 1'b1;
                        wdata_d = align_load;
                    end
                end else if (expire) begin
                    state_d   = ST_IDLE;
                    req_d     = 1'b0;
                    timeout_d = 1'b1;
                end else begin
                    stall = 1'b1;
                    cnt_d = cnt_q + 1'b1;
                end
            end
            default: begin
                state_d = ST_IDLE;
                req_d   = 1'b0;
            end
        endcase
    end

    // State, bus and result registers with synchronous active-low clear.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q     <= ST_IDLE;
            cnt_q       <= '0;
            op_q        <= '0;
            off_q       <= '0;
            mem_req_o   <= 1'b0;
            mem_we_o    <= 1'b0;
            mem_addr_o  <= '0;
            mem_sel_o   <= '0;
            mem_wdata_o <= '0;
            wd_o        <= '0;
            wreg_o      <= 1'b0;
            wdata_o     <= '0;
            misalign_o  <= 1'b0;
            timeout_o   <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            op_q        <= op_d;
            off_q       <= off_d;
            mem_req_o   <= req_d;
            mem_we_o    <= we_d;
            mem_addr_o  <= addr_d;
            mem_sel_o   <= sel_d;
            mem_wdata_o <= bus_wdata_d;
            wd_o        <= wd_d;
            wreg_o      <= wreg_d;
            wdata_o     <= wdata_d;
            misalign_o  <= misalign_d;
            timeout_o   <= timeout_d;
        end
    end

endmodule

// File: doc/mem_lsu.md
Name: mem_lsu

Overview:
- MEM stage of the 5-stage RISC-V core. Sits directly downstream of the execute stage, behind the EX/MEM register.
- Consumes the execute results: ALU op, effective address, store data, destination register and ALU result.
- Performs loads and stores over a single-outstanding req/ack data bus and stalls the pipeline while an access is in flight.
- Drives a registered result (MEM/WB boundary) to write-back.

Parameters:
- BUS_TIMEOUT, 0, cycles to wait for mem_ack_i before abandoning an access. 0 means wait forever.

Ports:
- clk  in  1  single clock; all state updates on the rising edge
- rst  in  1  reset; synchronous, active-low
- aluop_i  in  8  ALU op from the EX/MEM register
- mem_addr_i  in  32  effective address
- reg2_i  in  32  store data
- wd_i  in  5  destination register
- wreg_i  in  1  write-enable
- wdata_i  in  32  ALU result
- stall_req_o  out  1  pipeline stall request to ctrl
- mem_req_o  out  1  bus request
- mem_we_o  out  1  1 = store
- mem_addr_o  out  32  word-aligned bus address (bits [1:0] = 0)
- mem_sel_o  out  4  byte-lane enables
- mem_wdata_o  out  32  lane-replicated store data
- mem_ack_i  in  1  bus completion
- mem_rdata_i  in  32  load data, valid with ack
- wd_o  out  5  registered result: destination register
- wreg_o  out  1  registered result: write-enable
- wdata_o  out  32  registered result: data
- misalign_o  out  1  misaligned-access flag; registered, one cycle
- timeout_o  out  1  bus timeout pulse; registered, one cycle

Behaviour:
- Reset (rst=0 at a rising edge): state IDLE, and every output clears.
  - Cleared: mem_req_o, mem_we_o, mem_addr_o, mem_sel_o, mem_wdata_o, wd_o, wreg_o, wdata_o, misalign_o, timeout_o.
  - stall_req_o is combinational and reads 0 while rst=0.
- Reset mid-access: the request is dropped at that edge, and a later mem_ack_i is ignored.
- Memory ops: EXE_LB/LH/LW/LBU/LHU/SB/SH/SW_OP. Any other aluop_i is a pass-through.
- FSM states: IDLE, BUS.
- IDLE, pass-through op:
  - stall_req_o=0.
  - Next edge loads wd_o=wd_i, wreg_o=wreg_i, wdata_o=wdata_i (1-cycle latency).
- IDLE, memory op:
  - stall_req_o=1 combinationally.
  - Next edge registers the bus fields, sets mem_req_o=1 and moves to BUS.
  - The output register loads a bubble: wreg_o=0, wd_o=0, wdata_o=0.
- BUS:
  - mem_req_o and all bus fields stay constant; stall_req_o = ~mem_ack_i.
  - The output register loads a bubble each cycle without ack.
  - On mem_ack_i=1: mem_req_o drops at the edge and the state returns to IDLE.
  - Load result on ack: wd_o=wd_i, wreg_o=1, wdata_o = extracted load data.
  - Store result on ack: wreg_o=0.
- Minimum memory-op timing: op presented at T, request at T+1, ack at T+1, result visible at T+2.
- mem_ack_i in IDLE is ignored.
- Byte lanes are little-endian; o = mem_addr_i[1:0].
  - SB: sel=4'b0001<<o, wdata={4{reg2_i[7:0]}}.
  - SH: sel=4'b0011<<{o[1],1'b0}, wdata={2{reg2_i[15:0]}}.
  - SW: sel=4'b1111, wdata=reg2_i.
  - Loads use sel in the same pattern as the matching store and mem_we_o=0.
- Load extraction:
  - LB/LH sign-extend the selected byte/halfword.
  - LBU/LHU zero-extend.
  - LW takes the full word.
- Timeout (BUS_TIMEOUT>0):
  - A counter runs in BUS.
  - After BUS_TIMEOUT cycles without ack: drop the request, return to IDLE, timeout_o=1 for one cycle.
  - The result is a bubble, and stall_req_o=0 in that cycle.
  - An ack arriving in the same cycle as expiry takes priority (normal completion).

Optional Feature:
- Macro: MEM_MISALIGN_TRAP_EN.
- Defined:
  - Applies to a halfword access with o[0]=1, or a word access with o≠0.
  - No bus access and no stall.
  - Next edge: misalign_o=1 for one cycle, wreg_o=0.
- Undefined:
  - misalign_o is tied 0.
  - The offset is truncated: halfword uses o[1]; word ignores o.
  - The access proceeds normally.

Decomposition:
- Shared defines (existing defines header): memory op codes EXE_LB_OP…EXE_SW_OP, AluOpBus/RegBus/RegAddrBus widths, FSM state encodings.
- Sub-module mem_lsu_align (combinational) computes:
  - sel and lane-replicated wdata from op/offset/reg2;
  - extracted and extended load data from op/offset/rdata.
- The FSM, counter and output register stay in mem_lsu.

Test Plan:
- Pass-through: aluop=ADD, wd=5, wreg=1, wdata=0x1234 → next cycle wd_o=5, wreg_o=1, wdata_o=0x1234; stall_req_o never 1.
- LB, ack 1 cycle after req: addr=0x1003, rdata=0x80FF_0000 → sel=1000, mem_addr_o=0x1000, wdata_o=0xFFFF_FF80, stall_req_o high exactly 1 cycle.
- LHU, ack delayed 3 cycles: addr=0x2002, rdata=0xBEEF_0000 → sel=1100, wdata_o=0x0000_BEEF, bus fields stable all 3 wait cycles, bubbles emitted.
- SB: addr=0x10, reg2=0x0000_00AB → sel=0001, mem_wdata_o=0xABAB_ABAB, we=1, wreg_o=0 after ack.
- Reset during BUS, then ack 1 cycle later → req low after the reset edge, all outputs 0, late ack produces no write.
- LW at 0x1002:
  - with MEM_MISALIGN_TRAP_EN: misalign_o pulses, mem_req_o stays 0;
  - without it: mem_addr_o=0x1000, sel=1111.
  - With BUS_TIMEOUT=4 and no ack: timeout_o pulses after 4 cycles in BUS.
